// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - RV32I load/store initiator for a word-organised data memory
// Byte/halfword/word accesses become word accesses; sub-word stores use read-modify-write.
module lsu_mem_master #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_a_q, mem_a_d;

    logic        req_err;
    logic        fn_ok;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [31:0] merge_wd;

    // Request legality: funct3 must be a real RV32I load/store, aligned to its size and in range.
    always_comb begin
        fn_ok = 1'b0;
        case ({req_store, req_funct3})
            4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101,
            4'b1_000, 4'b1_001, 4'b1_010: fn_ok = 1'b1;
            default:                      fn_ok = 1'b0;
        endcase
        req_err = !fn_ok
                || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
                || (req_addr >= ADDR_LIMIT);
    end

    always_comb begin
        sel_byte = 8'h00;
        case (addr_lo_q)
            2'd0:    sel_byte = mem_RD[7:0];
            2'd1:    sel_byte = mem_RD[15:8];
            2'd2:    sel_byte = mem_RD[23:16];
            default: sel_byte = mem_RD[31:24];
        endcase
        sel_half = addr_lo_q[1] ? mem_RD[31:16] : mem_RD[15:0];
        load_val = mem_RD;
        case (funct3_q)
            3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
            3'b100:  load_val = {24'h000000, sel_byte};
            3'b101:  load_val = {16'h0000, sel_half};
            default: load_val = mem_RD;
        endcase
    end

    // Write data: full word for SW, otherwise the captured word with one lane replaced.
    always_comb begin
        merge_wd = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                merge_wd = word_q;
                case (addr_lo_q)
                    2'd0:    merge_wd[7:0]   = wdata_q[7:0];
                    2'd1:    merge_wd[15:8]  = wdata_q[7:0];
                    2'd2:    merge_wd[23:16] = wdata_q[7:0];
                    default: merge_wd[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01:   merge_wd = addr_lo_q[1] ? {wdata_q[15:0], word_q[15:0]}
                                             : {word_q[31:16], wdata_q[15:0]};
            default: merge_wd = wdata_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        word_d    = word_q;
        rdata_d   = rdata_q;
        mem_a_d   = mem_a_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d  = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata;
                    err_d     = req_err;
                    rdata_d   = 32'h0;
                    if (req_err) begin
                        state_d = DONE;
                    end else begin
                        mem_a_d = {req_addr[31:2], 2'b00};
                        if (!req_store)                 state_d = LOAD;
                        else if (req_funct3 == 3'b010)  state_d = WRITE;
                        else                            state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_val;
                state_d = DONE;
            end
            RMW_RD: begin
                word_d  = mem_RD;
                state_d = WRITE;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            word_q    <= 32'h0;
            rdata_q   <= 32'h0;
            mem_a_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            word_q    <= word_d;
            rdata_q   <= rdata_d;
            mem_a_q   <= mem_a_d;
        end
    end

    // Outputs decode straight from the state register so reset kills a write immediately.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_err   = (state_q == DONE) && err_q;
    assign rsp_rdata = rdata_q;
    assign mem_WE    = (state_q == WRITE);
    assign mem_A     = mem_a_q;
    assign mem_WD    = (state_q == WRITE) ? merge_wd : 32'h0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master
// Randomised requests checked every cycle against a queue-free reference model of the access rules.
module tb_lsu_mem_master;

    localparam int MW = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    lsu_mem_master #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    // Attached memory, plus a backdoor port used only for preloading during reset.
    logic [31:0] mem [MW];
    logic        bk_we = 1'b0;
    int          bk_idx = 0;
    logic [31:0] bk_val = 32'h0;
    always @(posedge clk) begin
        if (mem_WE)     mem[mem_A[7:2]] <= mem_WD;
        else if (bk_we) mem[bk_idx]     <= bk_val;
    end
    assign mem_RD = mem[mem_A[7:2]];

    logic [31:0] ref_mem [MW];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int          e_acc = -100, e_rsp = -100, e_we = -100;
    logic        e_err = 1'b0;
    logic [31:0] e_rd = 32'h0, e_wd = 32'h0, e_wa = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference rules: access size from funct3, legality, extension and lane masking by arithmetic.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic err, output int lat,
                                  output logic [31:0] rd, output logic [31:0] nw);
        int          size;
        bit          ok;
        int          shift;
        logic [31:0] v, mask, old;
        size  = 1 << f3[1:0];
        ok    = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !ok || ((a % size) != 0) || (a >= 32'(4 * MW));
        rd    = 32'h0;
        nw    = 32'h0;
        shift = int'(a % 4) * 8;
        if (err) begin
            lat = 1;
        end else if (!st) begin
            v = ref_mem[a / 4] >> shift;
            if (size == 1) begin
                v = v & 32'hFF;
                if (!f3[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            rd  = v;
            lat = 2;
        end else begin
            old  = ref_mem[a / 4];
            mask = (size == 4) ? 32'hFFFFFFFF : (((32'h1 << (8 * size)) - 32'h1) << shift);
            nw   = (old & ~mask) | ((wd << shift) & mask);
            lat  = (size == 4) ? 2 : 3;
        end
    endfunction

    // Per-cycle comparison of every output against the expectation window of the live request.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("req_ready", {31'h0, req_ready}, (cyc >= e_acc && cyc <= e_rsp) ? 32'h0 : 32'h1);
            chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, cyc == e_rsp});
            if (cyc == e_rsp) begin
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e_err});
                chk("rsp_rdata", rsp_rdata, e_rd);
            end
            chk("mem_WE", {31'h0, mem_WE}, {31'h0, cyc == e_we});
            if (cyc == e_we) begin
                chk("mem_A", mem_A, e_wa);
                chk("mem_WD", mem_WD, e_wd);
            end else begin
                chk("mem_WD_idle", mem_WD, 32'h0);
            end
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, output int acc_o,
                          output int seen_o, output logic [31:0] rd_o, output logic err_o);
        int          n;
        int          lat;
        logic        err;
        logic [31:0] rd, nw;
        acc_o  = -1;
        seen_o = -1;
        rd_o   = 32'h0;
        err_o  = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", n);
            req_valid = 1'b0;
            return;
        end
        model(st, f3, a, wd, err, lat, rd, nw);
        e_acc = cyc + 1;
        e_rsp = e_acc + lat - 1;
        e_we  = (st && !err) ? e_rsp - 1 : -100;
        e_err = err;
        e_rd  = rd;
        e_wd  = nw;
        e_wa  = {a[31:2], 2'b00};
        if (st && !err) ref_mem[a / 4] = nw;
        acc_o = e_acc;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #3;
            if (!hold) req_valid = 1'b0;
            if (rsp_valid) begin
                seen_o = cyc;
                rd_o   = rsp_rdata;
                err_o  = rsp_err;
                break;
            end
        end
        if (seen_o < 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 10 cycles, got %0d expected 1", 0);
        end
    endtask

    task automatic bk_write(input int idx, input logic [31:0] val);
        @(negedge clk);
        bk_we  = 1'b1;
        bk_idx = idx;
        bk_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    initial begin
        int          acc, seen, acc2, seen2;
        logic [31:0] rd, v;
        logic        er;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;

        // Reset state and preload
        for (int i = 0; i < MW; i++) bk_write(i, $urandom);
        bk_write(1, 32'h80FF7F01);
        bk_write(2, 32'h11223344);
        bk_write(4, 32'h12345678);
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_mem_WE", {31'h0, mem_WE}, 32'h0);
        chk("rst_mem_A", mem_A, 32'h0);
        chk("rst_mem_WD", mem_WD, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;

        // Reset asserted during the write cycle of an SW
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("sw_we_before_rst", {31'h0, mem_WE}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", {31'h0, mem_WE}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mid_mem_A", mem_A, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_mid_word4", mem[4], 32'h12345678);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Loads from word 1 = 0x80FF7F01
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 1'b0, acc, seen, rd, er);
        chk("lw_4", rd, 32'h80FF7F01);
        chk("lw_lat", 32'(seen - acc), 32'd1);
        do_req(1'b0, 3'b000, 32'h7, 32'h0, 1'b0, acc, seen, rd, er);
        chk("lb_7", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h7, 32'h0, 1'b0, acc, seen, rd, er);
        chk("lbu_7", rd, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h6, 32'h0, 1'b0, acc, seen, rd, er);
        chk("lh_6", rd, 32'hFFFF80FF);
        do_req(1'b0, 3'b101, 32'h4, 32'h0, 1'b0, acc, seen, rd, er);
        chk("lhu_4", rd, 32'h00007F01);
        chk("lhu_lat", 32'(seen - acc), 32'd1);

        // Sub-word stores into word 2 = 0x11223344
        do_req(1'b1, 3'b000, 32'h9, 32'h000000AB, 1'b0, acc, seen, rd, er);
        chk("sb_9_word", mem[2], 32'h1122AB44);
        chk("sb_lat", 32'(seen - acc), 32'd2);
        do_req(1'b1, 3'b001, 32'hA, 32'h0000CDEF, 1'b0, acc, seen, rd, er);
        chk("sh_a_word", mem[2], 32'hCDEFAB44);

        // Misaligned, out of range and illegal funct3
        do_req(1'b0, 3'b010, 32'h2, 32'h0, 1'b0, acc, seen, rd, er);
        chk("lw_2_err", {31'h0, er}, 32'h1);
        chk("lw_2_lat", 32'(seen - acc), 32'd0);
        do_req(1'b1, 3'b001, 32'h5, 32'h1234, 1'b0, acc, seen, rd, er);
        chk("sh_5_err", {31'h0, er}, 32'h1);
        do_req(1'b1, 3'b010, 32'h100, 32'h5555AAAA, 1'b0, acc, seen, rd, er);
        chk("sw_100_err", {31'h0, er}, 32'h1);
        do_req(1'b0, 3'b011, 32'h0, 32'h0, 1'b0, acc, seen, rd, er);
        chk("f3_011_err", {31'h0, er}, 32'h1);
        chk("f3_011_rdata", rd, 32'h0);

        // Back-to-back with req_valid held high
        v = $urandom;
        do_req(1'b1, 3'b010, 32'h0, v, 1'b1, acc, seen, rd, er);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, acc2, seen2, rd, er);
        chk("b2b_accept_cycle", 32'(acc2), 32'(seen + 2));
        chk("b2b_lw", rd, v);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'($urandom_range(4 * MW - 4, 4 * MW + 3));
                default: a = 32'($urandom_range(0, 4 * MW - 1));
            endcase
            do_req(st, f3, a, $urandom, 1'($urandom_range(0, 1)), acc, seen, rd, er);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < MW; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
